// File: rtl/i_mem_sync.sv
// i_mem_sync: synchronous-read instruction memory for the RV32I fetch path.
//
// A fetch request is accepted on req_valid && req_ready. One cycle later the
// single-entry response register presents the instruction, the echoed PC and
// fault flags. Faulting fetches (misaligned or out of range) return NOP_INSTR.
// A word-write load port allows programs to be loaded at run time.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (response register only)
//   req_valid   fetch request valid
//   req_ready   fetch request can be accepted this cycle
//   req_pc      byte address to fetch
//   resp_valid  response register holds a valid fetch
//   resp_ready  decode consumes the response
//   resp_instr  fetched instruction (NOP_INSTR on fault / after reset)
//   resp_pc     PC of the returned instruction
//   resp_fault  bit0 misaligned, bit1 out of range
//   flush       discard the held response (redirect)
//   ld_we       load-port write enable
//   ld_addr     load-port word index
//   ld_data     load-port write data
module i_mem_sync #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_pc,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_instr,
    output logic [31:0]                    resp_pc,
    output logic [1:0]                     resp_fault,
    input  logic                           flush,
    input  logic                           ld_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // 33 bits so the byte span stays representable even for a 4 GiB memory.
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          misaligned;
    logic          oor;
    logic          accept;

    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_instr_q;
    logic [31:0]   resp_pc_q;
    logic [1:0]    resp_fault_q;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge
    // offsets, so the single compare catches both ends of the window.
    always_comb begin
        offset     = req_pc - BASE_ADDR;
        idx        = offset[AW+1:2];
        // BASE_ADDR is word aligned, so offset[1:0] equals req_pc[1:0].
        misaligned = |offset[1:0];
        oor        = {1'b0, offset} >= SPAN;
    end

    // The load port owns the array for its cycle, so fetch reads and writes
    // never collide.
    always_comb begin
        req_ready = !ld_we && (!resp_valid_q || resp_ready || flush);
        accept    = req_valid && req_ready;
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        if (accept) begin
            resp_valid_d = 1'b1;
        end else if (resp_ready || flush) begin
            resp_valid_d = 1'b0;
        end
    end

    // Response register. Payload fields only change on accept, so a consumed
    // or flushed response leaves its last values visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_instr_q <= NOP_INSTR;
            resp_pc_q    <= 32'h0;
            resp_fault_q <= 2'b00;
        end else begin
            resp_valid_q <= resp_valid_d;
            if (accept) begin
                resp_pc_q    <= req_pc;
                resp_fault_q <= {oor, misaligned};
                resp_instr_q <= (oor || misaligned) ? NOP_INSTR : mem[idx];
            end
        end
    end

    // Memory is deliberately outside reset so a write in a reset cycle lands.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_instr = resp_instr_q;
    assign resp_pc    = resp_pc_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_i_mem_sync.sv
module tb_i_mem_sync;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] W0    = 32'h0050_0113;
    localparam logic [31:0] W1    = 32'h0021_2223;
    localparam logic [31:0] W2    = 32'h1111_1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_pc;
    logic [1:0]  resp_fault;
    logic        flush;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;

    i_mem_sync #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (32'h0000_0000),
        .INIT_FILE  (""),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_instr(resp_instr),
        .resp_pc   (resp_pc),
        .resp_fault(resp_fault),
        .flush     (flush),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  fault;
    } resp_t;

    resp_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [1:0] f);
        resp_t r;
        r.instr = instr;
        r.pc    = pc;
        r.fault = f;
        exp_q.push_back(r);
    endtask

    // Monitor: a new response must appear exactly one edge after each accept.
    initial begin
        logic  acc;
        resp_t e;
        forever begin
            @(posedge clk);
            acc = req_valid && req_ready && !rst;
            #1;
            if (acc) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got pc %08h expected no accept", resp_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_valid", {31'b0, resp_valid}, 32'd1);
                    chk("mon_instr", resp_instr, e.instr);
                    chk("mon_pc", resp_pc, e.pc);
                    chk("mon_fault", {30'b0, resp_fault}, {30'b0, e.fault});
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_pc = 32'h0; resp_ready = 1'b1;
        flush = 1'b0; ld_we = 1'b0; ld_addr = 4'h0; ld_data = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_instr", resp_instr, NOP);
        chk("rst_pc", resp_pc, 32'h0);
        chk("rst_fault", {30'b0, resp_fault}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        load(4'd0, W0);
        load(4'd1, W1);
        load(4'd2, W2);

        // Back-to-back fetches with resp_ready held high.
        @(negedge clk); req_valid = 1'b1; req_pc = 32'd0; push(W0, 32'd0, 2'b00);
        @(negedge clk); req_pc = 32'd4;  push(W1, 32'd4, 2'b00);
        // Fault cases.
        @(negedge clk); req_pc = 32'd6;  push(NOP, 32'd6, 2'b01);
        @(negedge clk); req_pc = 32'd64; push(NOP, 32'd64, 2'b10);
        @(negedge clk); req_pc = 32'd66; push(NOP, 32'd66, 2'b11);
        @(negedge clk); req_pc = 32'h8000_0000; push(NOP, 32'h8000_0000, 2'b10);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);

        // Hold for three cycles, then release and accept in the same cycle.
        resp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd4; push(W1, 32'd4, 2'b00);
        @(negedge clk); req_pc = 32'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
            chk("hold_valid", {31'b0, resp_valid}, 32'd1);
            chk("hold_pc", resp_pc, 32'd4);
            chk("hold_instr", resp_instr, W1);
            @(negedge clk);
        end
        resp_ready = 1'b1; push(W0, 32'd0, 2'b00);
        #1;
        chk("release_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);

        // Flush together with a new accept, then flush alone.
        resp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd0; push(W0, 32'd0, 2'b00);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); flush = 1'b1; req_valid = 1'b1; req_pc = 32'd8; push(W2, 32'd8, 2'b00);
        #1;
        chk("flush_acc_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk); flush = 1'b0; req_valid = 1'b0;
        #1;
        chk("flush_new_valid", {31'b0, resp_valid}, 32'd1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1;
        chk("flush_only_valid", {31'b0, resp_valid}, 32'd0);

        // Load write blocks the fetch; the next-cycle fetch sees new data.
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 4'd2; ld_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_pc = 32'd8;
        #1;
        chk("ld_blocks_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk); ld_we = 1'b0; push(32'hDEAD_BEEF, 32'd8, 2'b00);
        // Overwrite the word behind the held response.
        @(negedge clk); req_valid = 1'b0;
        ld_we = 1'b1; ld_addr = 4'd2; ld_data = 32'h1234_5678;
        @(negedge clk); ld_we = 1'b0;
        #1;
        chk("held_after_wr_instr", resp_instr, 32'hDEAD_BEEF);
        chk("held_after_wr_valid", {31'b0, resp_valid}, 32'd1);

        // Reset while holding; a load write in the reset cycle still lands.
        @(negedge clk);
        rst = 1'b1; ld_we = 1'b1; ld_addr = 4'd3; ld_data = 32'hCAFE_F00D;
        @(negedge clk); rst = 1'b0; ld_we = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_rst_instr", resp_instr, NOP);
        chk("mid_rst_pc", resp_pc, 32'h0);
        chk("mid_rst_fault", {30'b0, resp_fault}, 32'd0);
        resp_ready = 1'b1;
        @(negedge clk); req_valid = 1'b1; req_pc = 32'd0;  push(W0, 32'd0, 2'b00);
        @(negedge clk); req_pc = 32'd12; push(32'hCAFE_F00D, 32'd12, 2'b00);
        @(negedge clk); req_pc = 32'd8;  push(32'h1234_5678, 32'd8, 2'b00);
        @(negedge clk); req_valid = 1'b0;
        repeat (3) @(negedge clk);

        chk("pending_expect", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
